// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared constants and FSM encoding for the PS/2 scancode receiver.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t c_ST_IDLE   = 2'd0;
    localparam ps2_state_t c_ST_DATA   = 2'd1;
    localparam ps2_state_t c_ST_PARITY = 2'd2;
    localparam ps2_state_t c_ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    localparam int c_FILTER_LEN_DEF  = 8;
    localparam int c_TIMEOUT_CYC_DEF = 6250;

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Brief    : 2-flop synchronizer, glitch filter and falling-edge strobe.
// Revision : 1.0
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_fall
);

    localparam int c_CW = $clog2(FILTER_LEN + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [c_CW-1:0] r_cnt;

    // The level flips only on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            o_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            o_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                o_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_rx
// Brief    : PS/2 keyboard frame receiver with E0/F0 prefix decoding.
//            Define PS2_RX_TIMEOUT_EN to enable the mid-frame watchdog.
// Revision : 1.0
// ============================================================================
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = c_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF
) (
    input  logic       clkps2,
    input  logic       rst_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scancode,
    output logic       valid,
    output logic       released,
    output logic       extended,
    output logic       error
);

    ps2_state_t r_state;
    ps2_state_t w_state_nxt;
    logic       r_dsync1;
    logic       r_dsync2;
    logic       w_bit_ev;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_par_ok;
    logic       r_ext_flag;
    logic       r_rel_flag;
    logic       w_timeout;
    logic       w_good;
    logic       w_bad;

    if (FILTER_LEN < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("ps2_scancode_rx: FILTER_LEN and TIMEOUT_CYC must be >= 1");
    end

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clkps2),
        .rst_n  (rst_n),
        .i_line (ps2clk),
        .o_fall (w_bit_ev)
    );

    always_ff @(posedge clkps2 or negedge rst_n) begin
        if (!rst_n) begin
            r_dsync1 <= 1'b1;
            r_dsync2 <= 1'b1;
        end else begin
            r_dsync1 <= ps2data;
            r_dsync2 <= r_dsync1;
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
    logic [c_TW-1:0] r_to_cnt;

    // Saturates at TIMEOUT_CYC; a bit event in the expiry cycle takes priority.
    always_ff @(posedge clkps2 or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state == c_ST_IDLE || w_bit_ev) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TW'(TIMEOUT_CYC)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != c_ST_IDLE) && !w_bit_ev &&
                       (r_to_cnt == c_TW'(TIMEOUT_CYC));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clkps2 or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_bit_ev && !r_dsync2)              w_state_nxt = c_ST_DATA;
            c_ST_DATA:   if (w_bit_ev && r_bitcnt == 3'd7)       w_state_nxt = c_ST_PARITY;
            c_ST_PARITY: if (w_bit_ev)                           w_state_nxt = c_ST_STOP;
            c_ST_STOP:   if (w_bit_ev)                           w_state_nxt = c_ST_IDLE;
            default:                                             w_state_nxt = c_ST_IDLE;
        endcase
        if (w_timeout) w_state_nxt = c_ST_IDLE;
    end

    always_comb begin
        w_good = 1'b0;
        w_bad  = w_timeout;
        if (r_state == c_ST_STOP && w_bit_ev) begin
            w_good = r_dsync2 && r_par_ok;
            w_bad  = !(r_dsync2 && r_par_ok);
        end
    end

    always_ff @(posedge clkps2 or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_par_ok   <= 1'b0;
            r_ext_flag <= 1'b0;
            r_rel_flag <= 1'b0;
            scancode   <= 8'h00;
            released   <= 1'b0;
            extended   <= 1'b0;
            valid      <= 1'b0;
            error      <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (r_state == c_ST_IDLE && w_bit_ev) begin
                r_bitcnt <= '0;
            end
            if (r_state == c_ST_DATA && w_bit_ev) begin
                r_shift  <= {r_dsync2, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (r_state == c_ST_PARITY && w_bit_ev) begin
                r_par_ok <= ^{r_shift, r_dsync2};
            end
            if (w_bad) begin
                error      <= 1'b1;
                r_ext_flag <= 1'b0;
                r_rel_flag <= 1'b0;
            end else if (w_good) begin
                if (r_shift == PS2_PREFIX_EXT) begin
                    r_ext_flag <= 1'b1;
                end else if (r_shift == PS2_PREFIX_REL) begin
                    r_rel_flag <= 1'b1;
                end else begin
                    scancode   <= r_shift;
                    released   <= r_rel_flag;
                    extended   <= r_ext_flag;
                    valid      <= 1'b1;
                    r_ext_flag <= 1'b0;
                    r_rel_flag <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
